rs_dec_ser: RTL

- Serial-input decoder for the systematic (7,3) code with generator g(x) = x^4+x+1 (7'b0010011).
- Receives 7-bit codewords LSB-first from a data/strobe pair, as driven by par_to_ser, and recomputes the parity with a 3-stage pipelined polynomial divider.
- Forms a syndrome, corrects any single-bit error, flags uncorrectable patterns, and emits the 3-bit message with an output strobe.
- Sits at the receive end of the link, mirroring rs_enc_ser + par_to_ser.

---
 rtl/rs_dec_ser.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/rs_dec_ser.sv
// rs_dec_ser: serial-input (7,3) decoder, g(x)=x^4+x+1, 3-stage pipelined divider plus syndrome stage.
// Define RS_DEC_CORRECT_EN for single-error correction; otherwise the block only detects errors.
module rs_dec_ser #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    input  logic       clk_data_in,
    output logic [2:0] data_out,
    output logic       clk_data_out,
    output logic       err_corr,
    output logic       err_uncorr,
    output logic       sync_err
);
    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [3:0] G = 4'b0011;

    typedef enum logic {IDLE, RECV} state_t;

    state_t        r_state, w_state_nx;
    logic [1:0]    r_sync;
    logic [2:0]    r_cnt, w_cnt_nx;
    logic [IW-1:0] r_idle, w_idle_nx;
    logic [5:0]    r_sh, w_sh_nx;
    logic          w_edge, w_launch, w_tmo;

    logic [6:0]    r_frm;
    logic [3:0]    r_v;
    logic [5:0]    r_rem1, w_s1;
    logic [4:0]    r_rem2;
    logic [3:0]    r_rem3;
    logic [2:0]    r_m1, r_m2, r_m3;
    logic [3:0]    r_p1, r_p2, r_p3;
    logic [3:0]    w_syn;
    logic [2:0]    w_flip;
    logic          w_corr, w_unc;

    assign w_edge = r_sync[0] & ~r_sync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync  <= 2'b11;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idle  <= '0;
            r_sh    <= '0;
        end else begin
            r_sync  <= {r_sync[0], clk_data_in};
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idle  <= w_idle_nx;
            r_sh    <= w_sh_nx;
        end
    end

    // an edge always wins over a timeout landing in the same cycle
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idle_nx  = r_idle;
        w_sh_nx    = r_sh;
        w_launch   = 1'b0;
        w_tmo      = 1'b0;
        if (w_edge) begin
            w_idle_nx  = '0;
            w_sh_nx    = {data_in, r_sh[5:1]};
            w_launch   = (r_cnt == 3'd6);
            w_cnt_nx   = w_launch ? 3'd0 : r_cnt + 3'd1;
            w_state_nx = w_launch ? IDLE : RECV;
        end else if (r_state == RECV) begin
            w_tmo      = (TIMEOUT > 0) && (r_idle == IW'(TIMEOUT - 1));
            w_idle_nx  = w_tmo ? '0 : r_idle + IW'(1);
            w_cnt_nx   = w_tmo ? 3'd0 : r_cnt;
            w_sh_nx    = w_tmo ? '0 : r_sh;
            w_state_nx = w_tmo ? IDLE : RECV;
        end
    end

    // long division of {m,0000}: one dividend bit (6,5,4) retired per stage
    assign w_s1 = {r_frm[1:0], 4'b0000} ^ (r_frm[2] ? {G, 2'b00} : 6'b0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frm  <= '0;
            r_v    <= '0;
            r_rem1 <= '0;
            r_rem2 <= '0;
            r_rem3 <= '0;
            r_m1   <= '0;
            r_m2   <= '0;
            r_m3   <= '0;
            r_p1   <= '0;
            r_p2   <= '0;
            r_p3   <= '0;
        end else begin
            r_v    <= {r_v[2:0], w_launch};
            if (w_launch) r_frm <= {data_in, r_sh};
            r_rem1 <= w_s1;
            r_rem2 <= r_rem1[4:0] ^ (r_rem1[5] ? {G, 1'b0} : 5'b0);
            r_rem3 <= r_rem2[3:0] ^ (r_rem2[4] ? G : 4'b0);
            r_m1   <= r_frm[2:0];
            r_m2   <= r_m1;
            r_m3   <= r_m2;
            r_p1   <= r_frm[6:3];
            r_p2   <= r_p1;
            r_p3   <= r_p2;
        end
    end

    assign w_syn = r_rem3 ^ r_p3;

`ifdef RS_DEC_CORRECT_EN
    assign w_flip = (w_syn == 4'b0011) ? 3'b001 :
                    (w_syn == 4'b0110) ? 3'b010 :
                    (w_syn == 4'b1100) ? 3'b100 : 3'b000;
    assign w_corr = (w_flip != 3'b000) || $onehot(w_syn);
    assign w_unc  = (w_syn != 4'b0000) && !w_corr;
`else
    assign w_flip = 3'b000;
    assign w_corr = 1'b0;
    assign w_unc  = (w_syn != 4'b0000);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out     <= '0;
            clk_data_out <= 1'b0;
            err_corr     <= 1'b0;
            err_uncorr   <= 1'b0;
            sync_err     <= 1'b0;
        end else begin
            clk_data_out <= r_v[3];
            sync_err     <= w_tmo;
            if (r_v[3]) begin
                data_out   <= r_m3 ^ w_flip;
                err_corr   <= w_corr;
                err_uncorr <= w_unc;
            end
        end
    end
endmodule
